json_drive_cmd_serializer: RTL and testbench

//  Upstream feeder for the UART TX byte stage. Accepts one drive command (left/right speed

---
 rtl/json_drive_cmd_serializer.sv | 169 ++++++++++++++++
 tb/tb_json_drive_cmd_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/json_drive_cmd_serializer.sv
// Serializes one drive command into the ASCII frame {"T":<T>,"L":d.dd,"R":d.dd}\n, one byte per handshake.
// Optional macro JSON_CMD_COALESCE_EN adds a one-deep, latest-wins pending command register.
module json_drive_cmd_serializer #(
    parameter logic [7:0] T_CHAR = 8'h31,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_l_idx,
    input  logic [2:0]       cmd_r_idx,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       bidx_reg, bidx_next;
    logic [2:0]       l_reg, l_next, r_reg, r_next;
    logic [CNT_W-1:0] frames_reg, frames_next;
    logic             cmd_accept, tx_hs, last_byte;
    logic [7:0]       frame_byte;
    logic [1:0]       pos_l, pos_r;

    function automatic logic [2:0] clamp(input logic [2:0] idx);
        return (idx > 3'd4) ? 3'd4 : idx;
    endfunction

    // Character pos of "d.dd" for speed idx*0.25, idx already clamped to 0..4
    function automatic logic [7:0] speed_char(input logic [2:0] idx, input logic [1:0] pos);
        logic [7:0] c;
        case (pos)
            2'd0: c = (idx == 3'd4) ? 8'h31 : 8'h30;
            2'd1: c = 8'h2E;
            2'd2: begin
                case (idx)
                    3'd1:    c = 8'h32;
                    3'd2:    c = 8'h35;
                    3'd3:    c = 8'h37;
                    default: c = 8'h30;
                endcase
            end
            default: c = (idx == 3'd1 || idx == 3'd3) ? 8'h35 : 8'h30;
        endcase
        return c;
    endfunction

`ifdef JSON_CMD_COALESCE_EN
    logic       pend_reg, pend_next;
    logic [2:0] pl_reg, pl_next, pr_reg, pr_next;
    assign cmd_ready = !rst;
`else
    assign cmd_ready = !rst && (state_reg == IDLE);
`endif

    assign tx_valid    = (state_reg == SEND);
    assign busy        = (state_reg == SEND);
    assign tx_data     = (state_reg == SEND) ? frame_byte : 8'h00;
    assign frames_sent = frames_reg;
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign tx_hs       = tx_valid && tx_ready;
    assign last_byte   = (bidx_reg == 5'd25);
    assign pos_l       = 2'(bidx_reg - 5'd11);
    assign pos_r       = 2'(bidx_reg - 5'd20);

    always_comb begin
        case (bidx_reg)
            5'd0:                     frame_byte = 8'h7B;
            5'd1, 5'd3, 5'd7, 5'd9,
            5'd16, 5'd18:             frame_byte = 8'h22;
            5'd2:                     frame_byte = 8'h54;
            5'd4, 5'd10, 5'd19:       frame_byte = 8'h3A;
            5'd5:                     frame_byte = T_CHAR;
            5'd6, 5'd15:              frame_byte = 8'h2C;
            5'd8:                     frame_byte = 8'h4C;
            5'd11, 5'd12, 5'd13, 5'd14: frame_byte = speed_char(l_reg, pos_l);
            5'd17:                    frame_byte = 8'h52;
            5'd20, 5'd21, 5'd22, 5'd23: frame_byte = speed_char(r_reg, pos_r);
            5'd24:                    frame_byte = 8'h7D;
            5'd25:                    frame_byte = 8'h0A;
            default:                  frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        bidx_next   = bidx_reg;
        l_next      = l_reg;
        r_next      = r_reg;
        frames_next = frames_reg;
`ifdef JSON_CMD_COALESCE_EN
        pend_next   = pend_reg;
        pl_next     = pl_reg;
        pr_next     = pr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    l_next     = clamp(cmd_l_idx);
                    r_next     = clamp(cmd_r_idx);
                    bidx_next  = 5'd0;
                    state_next = SEND;
                end
            end
            default: begin
`ifdef JSON_CMD_COALESCE_EN
                if (cmd_accept) begin
                    pend_next = 1'b1;
                    pl_next   = clamp(cmd_l_idx);
                    pr_next   = clamp(cmd_r_idx);
                end
`endif
                if (tx_hs) begin
                    if (last_byte) begin
                        frames_next = frames_reg + CNT_W'(1);
                        state_next  = IDLE;
`ifdef JSON_CMD_COALESCE_EN
                        // A command arriving with '\n' supersedes any older pending one
                        pend_next = 1'b0;
                        if (cmd_accept) begin
                            l_next     = clamp(cmd_l_idx);
                            r_next     = clamp(cmd_r_idx);
                            bidx_next  = 5'd0;
                            state_next = SEND;
                        end else if (pend_reg) begin
                            l_next     = pl_reg;
                            r_next     = pr_reg;
                            bidx_next  = 5'd0;
                            state_next = SEND;
                        end
`endif
                    end else begin
                        bidx_next = bidx_reg + 5'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            bidx_reg   <= 5'd0;
            l_reg      <= 3'd0;
            r_reg      <= 3'd0;
            frames_reg <= '0;
`ifdef JSON_CMD_COALESCE_EN
            pend_reg   <= 1'b0;
            pl_reg     <= 3'd0;
            pr_reg     <= 3'd0;
`endif
        end else begin
            state_reg  <= state_next;
            bidx_reg   <= bidx_next;
            l_reg      <= l_next;
            r_reg      <= r_next;
            frames_reg <= frames_next;
`ifdef JSON_CMD_COALESCE_EN
            pend_reg   <= pend_next;
            pl_reg     <= pl_next;
            pr_reg     <= pr_next;
`endif
        end
    end
endmodule

// File: tb/tb_json_drive_cmd_serializer.sv
// Bench for json_drive_cmd_serializer: table vectors, reset/hold-off/coalesce sequences, random frames.
// Build with JSON_CMD_COALESCE_EN defined to exercise the pending-command path.
module tb_json_drive_cmd_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_l_idx;
    logic [2:0]  cmd_r_idx;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frames_sent;

    int vectors = 0;
    int errors  = 0;
    int exp_frames = 0;

    json_drive_cmd_serializer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_l_idx(cmd_l_idx), .cmd_r_idx(cmd_r_idx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] l;
        logic [2:0] r;
        int         mode;
        bit         scramble;
        string      exp_l;
        string      exp_r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else
            $display("ok   %s = %0h", name, act);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got [%s], expected [%s]", name, act.substr(0, act.len() - 2),
                     exp.substr(0, exp.len() - 2));
        end else
            $display("ok   %s = %s", name, act.substr(0, act.len() - 2));
    endtask

    // Reference: speed is min(idx,4) quarters, printed as d.dd
    function automatic string spd(input int idx);
        int v;
        v = ((idx > 4) ? 4 : idx) * 25;
        return $sformatf("%0d.%0d%0d", v / 100, (v / 10) % 10, v % 10);
    endfunction

    function automatic string model_frame(input int l, input int r);
        return $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", spd(l), spd(r));
    endfunction

    // Offer one command at a negedge; returns at the negedge after acceptance
    task automatic send_cmd(input logic [2:0] l, input logic [2:0] r);
        int t;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            vectors++;
            errors++;
            $display("FAIL cmd_ready_timeout: got 0, expected 1 within 200 cycles");
        end
        cmd_valid = 1'b1;
        cmd_l_idx = l;
        cmd_r_idx = r;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Collect n handshaked bytes; mode 0 ready high, 1 ready 1-of-3, 2 random
    task automatic collect(input int n, input int mode, input bit scramble, input bit inject,
                           output string got, output bit gap);
        int         cnt;
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        got = "";
        gap = 1'b0;
        cnt = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        while (cnt < n && cyc < 3000) begin
            if (prev_stall)
                chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (!tx_valid) gap = 1'b1;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 2);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (scramble) begin
                cmd_l_idx = 3'($urandom);
                cmd_r_idx = 3'($urandom);
            end
            if (inject) begin
                if (cyc == 5) begin
                    cmd_valid = 1'b1; cmd_l_idx = 3'd1; cmd_r_idx = 3'd1;
                end else if (cyc == 6) begin
                    cmd_valid = 1'b1; cmd_l_idx = 3'd3; cmd_r_idx = 3'd0;
                end else
                    cmd_valid = 1'b0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) begin
                got = $sformatf("%s%c", got, tx_data);
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        if (cnt < n) begin
            vectors++;
            errors++;
            $display("FAIL collect_timeout: got %0d bytes, expected %0d", cnt, n);
        end
    endtask

    task automatic check_after_frame(input string tag);
        chk({tag, "_tx_valid_after"}, tx_valid, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_frames_sent"}, frames_sent, exp_frames);
    endtask

    vec_t        vecs[5];
    string       got;
    string       exp;
    bit          gap;
    logic [63:0] act_v, exp_v;
    bit          rdy_err;
    int          rl, rr;

    initial begin
        vecs[0] = '{3'd2, 3'd2, 0, 1'b0, "0.50", "0.50"};
        vecs[1] = '{3'd1, 3'd4, 1, 1'b0, "0.25", "1.00"};
        vecs[2] = '{3'd7, 3'd0, 0, 1'b1, "1.00", "0.00"};
        vecs[3] = '{3'd3, 3'd5, 2, 1'b1, "0.75", "1.00"};
        vecs[4] = '{3'd0, 3'd6, 1, 1'b1, "0.00", "1.00"};

        rst = 1'b1; cmd_valid = 1'b0; cmd_l_idx = 3'd0; cmd_r_idx = 3'd0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frames_sent", frames_sent, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            send_cmd(vecs[i].l, vecs[i].r);
            chk($sformatf("vec%0d_first_byte", i), {tx_valid, tx_data}, {1'b1, 8'h7B});
            collect(26, vecs[i].mode, vecs[i].scramble, 1'b0, got, gap);
            exp = $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", vecs[i].exp_l, vecs[i].exp_r);
            chk_str($sformatf("vec%0d_frame", i), got, exp);
            exp_frames++;
            check_after_frame($sformatf("vec%0d", i));
        end

        // Reset mid-frame at byte index 10
        send_cmd(3'd2, 3'd2);
        collect(10, 0, 1'b0, 1'b0, got, gap);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_frames_sent", frames_sent, 16'd0);
        chk("midrst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        send_cmd(3'd4, 3'd1);
        collect(26, 0, 1'b0, 1'b0, got, gap);
        chk_str("post_rst_frame", got, model_frame(4, 1));
        exp_frames++;
        check_after_frame("post_rst");

`ifndef JSON_CMD_COALESCE_EN
        // cmd_valid held: hold-off during SEND and exactly one idle cycle between frames
        @(negedge clk);
        act_v = '0;
        exp_v = '0;
        rdy_err = 1'b0;
        tx_ready = 1'b1;
        cmd_l_idx = 3'd2;
        cmd_r_idx = 3'd2;
        for (int c = 0; c < 55; c++) begin
            act_v[c] = tx_valid;
            exp_v[c] = (c >= 1 && c <= 26) || (c >= 28 && c <= 53);
            if (busy && cmd_ready) rdy_err = 1'b1;
            cmd_valid = (c < 54);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("holdoff_valid_pattern", act_v, exp_v);
        chk("holdoff_cmd_ready_in_send", rdy_err, 1'b0);
        exp_frames += 2;
        check_after_frame("holdoff");
`else
        // B then C offered mid-frame: C follows A with no bubble, B dropped
        send_cmd(3'd2, 3'd2);
        collect(52, 0, 1'b0, 1'b1, got, gap);
        chk_str("coalesce_frames", got, {model_frame(2, 2), model_frame(3, 0)});
        chk("coalesce_no_gap", gap, 1'b0);
        exp_frames += 2;
        check_after_frame("coalesce");
`endif

        for (int k = 0; k < 8; k++) begin
            rl = $urandom_range(0, 7);
            rr = $urandom_range(0, 7);
            send_cmd(3'(rl), 3'(rr));
            collect(26, 2, 1'b1, 1'b0, got, gap);
            chk_str($sformatf("rand%0d_frame_l%0d_r%0d", k, rl, rr), got, model_frame(rl, rr));
            exp_frames++;
            check_after_frame($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
